seq_shift_add_mult: RTL and testbench

Sequential unsigned N×N→2N multiplier controller that sequences a single shared N-bit ripple-carry adder (`full_adder_nbit`) through N shift-and-add iterations. The block sits beside the adder datapath in the ALU lab design and serves as its first multi-cycle consumer. A start/done handshake exposes it to a CPU-style sequencer.

---
 rtl/mult_pkg.sv | 10 +
 rtl/full_adder_nbit.sv | 24 ++
 rtl/seq_shift_add_mult.sv | 88 ++++++++
 tb/tb_seq_shift_add_mult.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int MULT_W = 32;

endpackage

// File: rtl/full_adder_nbit.sv
// N-bit ripple-carry adder; purely combinational.
module full_adder_nbit #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned NxN->2N multiplier: one shared ripple adder stepped
// through N shift-and-add iterations behind a start/done handshake.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int N = MULT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);

  logic [1:0]    state;
  logic [N-1:0]  a;
  logic [N-1:0]  q;
  logic [N-1:0]  m;
  logic          c;
  logic [CW-1:0] count;

  logic [N-1:0]  add_sum;
  logic          add_cout;
  logic [N:0]    acc;
  logic [N-1:0]  a_nxt;
  logic [N-1:0]  q_nxt;

  full_adder_nbit #(.N(N)) u_adder (
    .a    (a),
    .b    (m),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // c is cleared by every shift, so {c,a} equals {0,a} on the no-add path.
  always_comb begin
    acc   = q[0] ? {add_cout, add_sum} : {c, a};
    a_nxt = acc[N:1];
    q_nxt = {acc[0], q[N-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a       <= '0;
      q       <= '0;
      m       <= '0;
      c       <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            m     <= multiplicand;
            q     <= multiplier;
            a     <= '0;
            c     <= 1'b0;
            count <= '0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          a     <= a_nxt;
          q     <= q_nxt;
          c     <= 1'b0;
          count <= count + 1'b1;
          if (count == CW'(N - 1)) begin
            product <= {a_nxt, q_nxt};
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult at N=32 plus a small N=4 instance.
module tb_seq_shift_add_mult;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  multiplicand = '0;
  logic [N-1:0]  multiplier = '0;
  logic          busy;
  logic          done;
  logic [2*N-1:0] product;

  logic          start4 = 1'b0;
  logic [3:0]    m4 = '0;
  logic [3:0]    q4 = '0;
  logic          busy4;
  logic          done4;
  logic [7:0]    product4;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  seq_shift_add_mult #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  seq_shift_add_mult #(.N(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .start        (start4),
    .multiplicand (m4),
    .multiplier   (q4),
    .busy         (busy4),
    .done         (done4),
    .product      (product4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] mm, input logic [31:0] qq);
    return 64'(mm) * 64'(qq);
  endfunction

  task automatic pop_check(input string tag);
    if (sb.size() == 0) check({tag, "_sb_empty"}, 64'd1, 64'd0);
    else check(tag, product, sb.pop_front());
  endtask

  // One operation; operands are scrambled right after capture.
  task automatic do_op(input string tag, input logic [31:0] mm, input logic [31:0] qq);
    int busy_cnt;
    int done_cnt;
    int done_at;
    logic [63:0] prev;
    @(negedge clk);
    multiplicand = mm;
    multiplier   = qq;
    start        = 1'b1;
    sb.push_back(model(mm, qq));
    prev = product;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int i = 1; i <= N + 4; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = i;
          pop_check({tag, "_product"});
        end
      end
      if (busy && done) check({tag, "_busy_done_excl"}, 64'd1, 64'd0);
      if (i == N) check({tag, "_product_hold"}, product, prev);
    end
    if (done_at == 0 && sb.size() != 0) void'(sb.pop_front());
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(N));
    check({tag, "_done_cycle"}, 64'(done_at), 64'(N + 1));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    int d1, d2, bc;
    int busy_cnt4, done_at4;

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    check("reset_product4", 64'(product4), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("zero", 32'h0000_0007, 32'h0000_0000);
    do_op("small", 32'd3, 32'd5);
    do_op("shift16", 32'h0001_0000, 32'h0001_0000);
    do_op("carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int r = 0; r < 4; r++) do_op("rand", $urandom, $urandom);

    // start held high through BUSY and DONE, operands swapped mid-BUSY
    @(negedge clk);
    multiplicand = 32'h1234_5678;
    multiplier   = 32'h9ABC_DEF0;
    start        = 1'b1;
    sb.push_back(model(32'h1234_5678, 32'h9ABC_DEF0));
    @(posedge clk);
    d1 = 0; d2 = 0; bc = 0;
    for (int i = 1; i <= 72; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (busy && done) check("hs_busy_done_excl", 64'd1, 64'd0);
      if (done) begin
        if (d1 == 0) d1 = i; else d2 = i;
        pop_check("hs_product");
      end
      if (i == 3) begin
        multiplicand = 32'h0000_BEEF;
        multiplier   = 32'h0000_0101;
      end
      if (i == N + 2) begin
        check("hs_idle_busy", 64'(busy), 64'd0);
        check("hs_idle_done", 64'(done), 64'd0);
        sb.push_back(model(32'h0000_BEEF, 32'h0000_0101));
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    while (sb.size() != 0) void'(sb.pop_front());
    check("hs_first_done", 64'(d1), 64'(N + 1));
    check("hs_second_done", 64'(d2), 64'(2 * N + 3));
    check("hs_busy_total", 64'(bc), 64'(2 * N));

    // reset at iteration 10
    @(negedge clk);
    multiplicand = 32'hFFFF_0000;
    multiplier   = 32'h0000_FFFF;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 10; i++) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("after_rst", 32'd6, 32'd7);

    // N=4 instance
    @(negedge clk);
    m4 = 4'hF;
    q4 = 4'hF;
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    m4 = 4'h0;
    busy_cnt4 = 0; done_at4 = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (busy4) busy_cnt4++;
      if (done4 && done_at4 == 0) begin
        done_at4 = i;
        check("n4_product", 64'(product4), 64'hE1);
      end
    end
    check("n4_busy_cycles", 64'(busy_cnt4), 64'd4);
    check("n4_done_cycle", 64'(done_at4), 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
